// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Constants shared by the FIR filter and its downstream stages
//               so that sample width and pipeline-fill latency stay consistent.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // Sample width of the filter datapath
    localparam int FIR_N    = 16;

    // Filter fill latency: 3 delay taps plus the output register
    localparam int FIR_FILL = 4;

    // Bit width needed to index v distinct values, never less than 1
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO. rdata presents the head entry
//               whenever the FIFO is non-empty and reads as zero when empty.
//               Occupancy is tracked explicitly; full/empty derive from it.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [N-1:0]             wdata,
    output logic [N-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] c_level_full = LW'(DEPTH);

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    logic w_push;
    logic w_pop;

    // A pop frees the slot on the same edge, so a full FIFO still accepts a push then
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    assign full  = (r_level == c_level_full);
    assign empty = (r_level == '0);
    assign level = r_level;
    assign rdata = empty ? '0 : r_mem[r_rptr];

    // Storage is intentionally left unreset; only pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers wrap naturally; occupancy moves by +1/-1/0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_output_decimator.sv
`default_nettype none
// ============================================================================
// Module      : fir_output_decimator
// Description : Discards the filter fill samples after reset, keeps every
//               D-th sample thereafter and buffers kept samples in a small
//               show-ahead FIFO drained over valid/ready. A kept sample that
//               finds the FIFO full is dropped and raises a sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_output_decimator
    import fir_pkg::*;
#(
    parameter int N     = FIR_N,
    parameter int D     = 4,
    parameter int SKIP  = FIR_FILL,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             data_in,
    output logic [N-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clear
);

    localparam int SKW = clog2_min1(SKIP + 1);
    localparam int PW  = clog2_min1(D);
    localparam logic [SKW-1:0] c_skip_max   = SKW'(SKIP);
    localparam logic [PW-1:0]  c_phase_last = PW'(D - 1);

    logic [SKW-1:0] r_skip_cnt;
    logic [PW-1:0]  r_phase;
    logic           r_overflow;

    logic w_active;
    logic w_capture;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_full;
    logic w_empty;

    // Skip counter reaching SKIP marks the first sample worth keeping
    assign w_active  = (r_skip_cnt == c_skip_max);
    assign w_capture = w_active && (r_phase == '0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    assign out_valid = !w_empty;
    assign overflow  = r_overflow;

    // Count discarded fill samples, saturating at SKIP
    always_ff @(posedge clk) begin
        if (reset) begin
            r_skip_cnt <= '0;
        end else if (!w_active) begin
            r_skip_cnt <= r_skip_cnt + SKW'(1);
        end
    end

    // Decimation phase 0..D-1, starts running on the first kept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
        end else if (w_active) begin
            r_phase <= (r_phase == c_phase_last) ? '0 : r_phase + PW'(1);
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps it set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clear) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (data_in),
        .rdata (out_data),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule
`default_nettype wire
